// File: rtl/apb_req_master.sv
// ---------------------------------------------------------------------------
// apb_req_master
//
// APB initiator. Accepts one request at a time on a valid/ready request
// channel, runs it as an APB SETUP + ACCESS transfer (honouring PREADY wait
// states), and returns read data / error status on a valid/ready response
// channel. A transfer whose slave never answers is aborted after
// TIMEOUT_CYCLES consecutive wait states and reported as an error.
//
// State table
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | req_ready=1, waiting for req_valid; APB bus idle
//   ST_SETUP  | PSEL=1, PENABLE=0, single cycle
//   ST_ACCESS | PSEL=1, PENABLE=1, waiting for PREADY or timeout
//   ST_RESP   | rsp_valid=1, response held until rsp_ready
//
// Parameters
//   APB_ADDR_WIDTH  width of PADDR and req_addr
//   TIMEOUT_CYCLES  max consecutive ACCESS cycles with PREADY=0 (0 = never)
//
// Ports
//   HCLK, HRESETn                   clock, async active-low reset
//   req_valid/ready/write/addr/wdata request channel (upstream)
//   rsp_valid/ready/rdata/err/timeout response channel (upstream)
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE APB request outputs
//   PRDATA/PREADY/PSLVERR           APB completion inputs
// ---------------------------------------------------------------------------
module apb_req_master #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]               req_wdata,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,

    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    // A zero timeout still needs a legal (1-bit) counter.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    // Word-aligned APB address: the two byte-offset bits are forced to 0.
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_MASK = {{(APB_ADDR_WIDTH-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             timeout_hit;

    // Saturating increment; the compare uses the incremented value so the
    // abort happens in the TIMEOUT_CYCLES-th stalled ACCESS cycle itself.
    always_comb begin
        wait_cnt_inc = wait_cnt;
        timeout_hit  = 1'b0;
        if (wait_cnt != CNT_MAX) begin
            wait_cnt_inc = wait_cnt + CNT_W'(1);
        end
        if ((TIMEOUT_CYCLES != 0) && (wait_cnt_inc == CNT_LIMIT)) begin
            timeout_hit = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PWRITE      <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        PADDR     <= req_addr & ADDR_MASK;
                        PWDATA    <= req_write ? req_wdata : 32'h0;
                        PWRITE    <= req_write;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= ST_RESP;
                    end else begin
                        // PRDATA/PSLVERR are meaningless while the slave stalls.
                        wait_cnt <= wait_cnt_inc;
                        if (timeout_hit) begin
                            rsp_rdata   <= 32'h0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_valid   <= 1'b1;
                            PSEL        <= 1'b0;
                            PENABLE     <= 1'b0;
                            state       <= ST_RESP;
                        end
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_master.sv
// ---------------------------------------------------------------------------
// tb_apb_req_master
//
// Self-checking bench for apb_req_master (TIMEOUT_CYCLES=4). Each transfer's
// expectations (aligned address, ACCESS cycle count, response fields) are
// computed from the transfer description: wait states, slave data/error and
// response back-pressure.
// ---------------------------------------------------------------------------
module tb_apb_req_master;

    localparam int AW = 12;
    localparam int TO = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [31:0]   PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    int checks = 0;
    int errors = 0;

    // Request presented while a response is back-pressured.
    logic          next_write = 1'b0;
    logic [AW-1:0] next_addr = '0;
    logic [31:0]   next_wdata = '0;

    apb_req_master #(
        .APB_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // One full transfer starting from an IDLE window. waits = number of
    // PREADY=0 cycles the slave inserts before answering; TO or more means
    // the slave never answers in time.
    task automatic do_xfer(input string name, input logic wr, input logic [AW-1:0] addr,
                           input logic [31:0] wdata, input int waits,
                           input logic [31:0] rdata, input logic slverr,
                           input int rsp_delay, input logic hold_next);
        logic [AW-1:0] exp_paddr;
        logic [31:0]   exp_pwdata;
        logic          exp_to;
        int            exp_acc;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        int            acc;
        logic          done;

        exp_paddr  = addr & ~AW'(3);
        exp_pwdata = wr ? wdata : 32'h0;
        exp_to     = (waits >= TO);
        exp_acc    = exp_to ? TO : waits + 1;
        exp_rdata  = (exp_to || wr) ? 32'h0 : rdata;
        exp_err    = exp_to ? 1'b1 : slverr;

        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = (rsp_delay == 0);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_req_ready: got %b want 1", name, req_ready);
        end
        tick();

        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
        req_write = 1'($urandom);
        PREADY    = 1'($urandom);
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PWRITE !== wr || PADDR !== exp_paddr ||
            PWDATA !== exp_pwdata || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s setup: got psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h rr=%b want 1 0 %b %h %h 0",
                     name, PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, wr, exp_paddr, exp_pwdata);
        end
        tick();

        acc  = 0;
        done = 1'b0;
        while (!done && acc < 64) begin
            if (PSEL === 1'b0) begin
                done = 1'b1;
            end else begin
                checks++;
                if (PENABLE !== 1'b1 || PWRITE !== wr || PADDR !== exp_paddr ||
                    PWDATA !== exp_pwdata || rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s access[%0d]: got pen=%b pwrite=%b paddr=%h pwdata=%h rv=%b want 1 %b %h %h 0",
                             name, acc, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, wr, exp_paddr, exp_pwdata);
                end
                PREADY  = (acc == waits);
                PRDATA  = (acc == waits) ? rdata : $urandom;
                PSLVERR = (acc == waits) ? slverr : 1'($urandom);
                acc++;
                tick();
            end
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = $urandom;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s psel_never_dropped: got %0d access cycles want %0d", name, acc, exp_acc);
        end

        checks++;
        if (acc !== exp_acc) begin
            errors++;
            $display("FAIL %s access_cycles: got %0d want %0d", name, acc, exp_acc);
        end

        for (int i = 0; i <= rsp_delay; i++) begin
            if (hold_next && i > 0) begin
                req_valid = 1'b1;
                req_write = next_write;
                req_addr  = next_addr;
                req_wdata = next_wdata;
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err ||
                rsp_timeout !== exp_to || req_ready !== 1'b0 || PSEL !== 1'b0 ||
                PENABLE !== 1'b0 || PADDR !== exp_paddr) begin
                errors++;
                $display("FAIL %s resp[%0d]: got rv=%b rdata=%h err=%b to=%b rr=%b psel=%b pen=%b paddr=%h want 1 %h %b %b 0 0 0 %h",
                         name, i, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, req_ready, PSEL,
                         PENABLE, PADDR, exp_rdata, exp_err, exp_to, exp_paddr);
            end
            if (i == rsp_delay) rsp_ready = 1'b1;
            tick();
        end

        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || PSEL !== 1'b0) begin
            errors++;
            $display("FAIL %s post_handshake: got rv=%b rr=%b psel=%b want 0 1 0",
                     name, rsp_valid, req_ready, PSEL);
        end
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PADDR !== '0 || PWDATA !== '0 ||
            PWRITE !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0 ||
            rsp_timeout !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: got psel=%b pen=%b paddr=%h pwdata=%h pwrite=%b rv=%b rdata=%h err=%b to=%b rr=%b want all 0, rr=1",
                     PSEL, PENABLE, PADDR, PWDATA, PWRITE, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, req_ready);
        end
        HRESETn = 1'b1;
        tick();
        tick();
        checks++;
        if (PSEL !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_idle: got psel=%b rv=%b rr=%b want 0 0 1", PSEL, rsp_valid, req_ready);
        end
    endtask

    task automatic test_write();
        do_xfer("write_0x4", 1'b1, 12'h004, 32'hA5A5_A5A5, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    endtask

    task automatic test_wait_read();
        do_xfer("read_wait3", 1'b0, 12'h018, 32'h1234_5678, 3, 32'h0000_0081, 1'b0, 0, 1'b0);
    endtask

    task automatic test_slverr();
        do_xfer("read_slverr", 1'b0, 12'h007, 32'h0, 0, 32'h0BAD_F00D, 1'b1, 0, 1'b0);
    endtask

    task automatic test_timeout();
        do_xfer("timeout", 1'b0, 12'h100, 32'h0, 1000, 32'h5555_AAAA, 1'b0, 0, 1'b0);
        do_xfer("after_timeout", 1'b0, 12'h104, 32'h0, 1, 32'hCAFE_0001, 1'b0, 0, 1'b0);
        do_xfer("timeout_write", 1'b1, 12'h208, 32'h7777_1111, TO, 32'h0, 1'b0, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        next_write = 1'b1;
        next_addr  = 12'h3F2;
        next_wdata = 32'h0102_0304;
        do_xfer("bp_first", 1'b0, 12'h010, 32'h0, 0, 32'h0000_0042, 1'b0, 5, 1'b1);
        do_xfer("bp_second", next_write, next_addr, next_wdata, 0, 32'h0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_async_reset();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 12'h020;
        tick();
        req_valid = 1'b0;
        tick();
        PREADY = 1'b0;
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
            errors++;
            $display("FAIL arst_in_access: got psel=%b pen=%b want 1 1", PSEL, PENABLE);
        end
        #2;
        HRESETn = 1'b0;
        #1;
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL arst_immediate: got psel=%b pen=%b rv=%b rr=%b want 0 0 0 1",
                     PSEL, PENABLE, rsp_valid, req_ready);
        end
        tick();
        HRESETn = 1'b1;
        tick();
        do_xfer("read_after_arst", 1'b0, 12'h02C, 32'h0, 2, 32'h1357_9BDF, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            do_xfer($sformatf("rand%0d", n), 1'($urandom), AW'($urandom), $urandom,
                    int'($urandom_range(0, TO + 1)), $urandom, 1'($urandom),
                    int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_wait_read();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
